// File: rtl/acc_drain.sv
// acc_drain
//   Captures an accumulator word on request, reloads the accumulator on the
//   same edge, and streams the captured word out LSB chunk first over a
//   valid/ready handshake. The chunk count (1, 2 or 4) is selected by mode;
//   accumulator bits above the selected count are discarded.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   rst       : synchronous active-high reset
//   start     : request to capture and drain acc_val (honoured in IDLE only)
//   mode      : chunk count select, 00=1, 01=2, 10/11=4
//   acc_val   : current accumulator value
//   acc_cset  : reload strobe to the accumulator, same edge as the capture
//   busy      : drain in progress
//   out_data  : current chunk (zero while idle)
//   out_valid : out_data holds a valid chunk
//   out_ready : consumer accepts the chunk
//   out_last  : current chunk is the final one
//   done      : one-cycle pulse in the cycle after the final handshake
module acc_drain #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [MAC_ACC_WIDTH-1:0] acc_val,
    output logic                     acc_cset,
    output logic                     busy,
    output logic [MAC_MIN_WIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [MAC_ACC_WIDTH-1:0] shreg_q;
    logic [2:0]               cnt_q;
    logic                     done_q;

    logic                     capture;
    logic                     handshake;
    logic                     final_hs;
    logic [2:0]               chunks_dec;

    // Chunk count decode; both upper encodings select the full four chunks.
    always_comb begin
        chunks_dec = 3'd4;
        case (mode)
            2'b00:   chunks_dec = 3'd1;
            2'b01:   chunks_dec = 3'd2;
            default: chunks_dec = 3'd4;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        handshake = 1'b0;
        final_hs  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                // rst gating keeps the accumulator from reloading while
                // the capture itself is suppressed by reset.
                capture = start & ~rst;
                if (capture) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = shreg_q[MAC_MIN_WIDTH-1:0];
                out_last  = (cnt_q == 3'd1);
                handshake = out_ready;
                final_hs  = out_ready & (cnt_q == 3'd1);
                if (final_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign acc_cset = capture;
    assign done     = done_q;

    // Shift register, remaining-chunk counter and registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= final_hs;
            if (capture) begin
                shreg_q <= acc_val;
                cnt_q   <= chunks_dec;
            end else if (handshake) begin
                shreg_q <= shreg_q >> MAC_MIN_WIDTH;
                cnt_q   <= cnt_q - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain
//   Directed bench for acc_drain at default widths (8-bit chunks, 32-bit
//   accumulator). Inputs change and outputs are sampled at the falling edge.
//   Each step compares the packed status {acc_cset, busy, out_valid,
//   out_last, done, out_data} against a hand-computed value.
module tb_acc_drain;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] acc_val;
    logic        acc_cset;
    logic        busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;

    int errors;
    int checks;

    logic [12:0] obs;
    assign obs = {acc_cset, busy, out_valid, out_last, done, out_data};

    acc_drain #(
        .MAC_MIN_WIDTH(8),
        .MAC_ACC_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .acc_val  (acc_val),
        .acc_cset (acc_cset),
        .busy     (busy),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status word: {cset, busy, valid, last, done, data[7:0]}
    task automatic test_reset();
        logic [12:0] exp;
        rst = 1'b1; start = 1'b1; mode = 2'b10; acc_val = 32'h12345678;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            exp = 13'h0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, exp);
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0000) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, 13'h0000);
        end
        // start held through reset must not have captured anything
        @(negedge clk); #1;
        checks++;
        if (obs !== 13'h0000) begin
            errors++;
            $display("FAIL reset_no_capture: got %h want %h", obs, 13'h0000);
        end
    endtask

    task automatic test_four_chunks();
        logic [12:0] exp [7];
        exp[0] = {5'b10000, 8'h00};
        exp[1] = {5'b01100, 8'h78};
        exp[2] = {5'b01100, 8'h56};
        exp[3] = {5'b01100, 8'h34};
        exp[4] = {5'b01110, 8'h12};
        exp[5] = {5'b00001, 8'h00};
        exp[6] = {5'b00000, 8'h00};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = (i == 0); mode = 2'b10; acc_val = 32'h12345678;
            out_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL four_chunks[%0d]: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_single_chunk();
        logic [12:0] exp [4];
        exp[0] = {5'b10000, 8'h00};
        exp[1] = {5'b01110, 8'hDD};
        exp[2] = {5'b00001, 8'h00};
        exp[3] = {5'b00000, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = (i == 0); mode = 2'b00; acc_val = 32'hAABBCCDD;
            out_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL single_chunk[%0d]: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] exp [8];
        logic        rdy [8];
        int          hs;
        exp[0] = {5'b10000, 8'h00}; rdy[0] = 1'b0;
        exp[1] = {5'b01100, 8'hEF}; rdy[1] = 1'b0;
        exp[2] = {5'b01100, 8'hEF}; rdy[2] = 1'b0;
        exp[3] = {5'b01100, 8'hEF}; rdy[3] = 1'b0;
        exp[4] = {5'b01100, 8'hEF}; rdy[4] = 1'b1;
        exp[5] = {5'b01110, 8'hBE}; rdy[5] = 1'b1;
        exp[6] = {5'b00001, 8'h00}; rdy[6] = 1'b1;
        exp[7] = {5'b00000, 8'h00}; rdy[7] = 1'b1;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = (i == 0); mode = 2'b01; acc_val = 32'h0000BEEF;
            out_ready = rdy[i];
            #1;
            if (out_valid && out_ready) hs++;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL backpressure[%0d]: got %h want %h", i, obs, exp[i]);
            end
        end
        checks++;
        if (hs !== 2) begin
            errors++;
            $display("FAIL backpressure_handshakes: got %0d want 2", hs);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp [10];
        exp[0] = {5'b10000, 8'h00};
        exp[1] = {5'b01100, 8'h44};
        exp[2] = {5'b01100, 8'h33};
        exp[3] = {5'b01100, 8'h22};
        exp[4] = {5'b01110, 8'h11};
        exp[5] = {5'b10001, 8'h00};
        exp[6] = {5'b01100, 8'hD4};
        exp[7] = {5'b01110, 8'hC3};
        exp[8] = {5'b00001, 8'h00};
        exp[9] = {5'b00000, 8'h00};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (i == 0) begin
                start = 1'b1; mode = 2'b10; acc_val = 32'h11223344;
            end else if (i < 5) begin
                // start hammered during SEND with a different word and mode
                start = 1'b1; mode = 2'b00; acc_val = 32'hFFFFFFFF;
            end else if (i == 5) begin
                start = 1'b1; mode = 2'b01; acc_val = 32'hA1B2C3D4;
            end else begin
                start = 1'b0; mode = 2'b00; acc_val = 32'h0;
            end
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [12:0] exp [10];
        exp[0] = {5'b10000, 8'h00};
        exp[1] = {5'b01100, 8'h0D};
        exp[2] = {5'b01100, 8'hF0};
        exp[3] = {5'b01100, 8'hFE};
        exp[4] = {5'b00000, 8'h00};
        exp[5] = {5'b00000, 8'h00};
        exp[6] = {5'b10000, 8'h00};
        exp[7] = {5'b01100, 8'h69};
        exp[8] = {5'b01110, 8'h5A};
        exp[9] = {5'b00001, 8'h00};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            rst   = (i == 3);
            start = (i == 0) || (i == 6);
            mode  = (i < 6) ? 2'b10 : 2'b01;
            acc_val = (i < 6) ? 32'hCAFEF00D : 32'h00005A69;
            #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid_drain[%0d]: got %h want %h", i, obs, exp[i]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0000) begin
            errors++;
            $display("FAIL reset_mid_drain_tail: got %h want %h", obs, 13'h0000);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; start = 1'b0; mode = 2'b00; acc_val = '0; out_ready = 1'b0;
        test_reset();
        test_four_chunks();
        test_single_chunk();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
